tcdm_bank_resp_gen: RTL and testbench



---
 rtl/tcdm_interco_pkg.sv | 25 ++
 rtl/tcdm_resp_delay_line.sv | 31 +++
 rtl/tcdm_bank_resp_gen.sv | 98 +++++++++
 tb/tb_tcdm_bank_resp_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tcdm_interco_pkg.sv
// Shared types and constants for the TCDM interconnect response path.
// The id field is sized for the widest supported ID_WIDTH; narrower configurations zero-extend.
package tcdm_interco_pkg;

    localparam int unsigned MAX_BANK_LAT = 4;
    localparam int unsigned MAX_ID_WIDTH = 6;

    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
        logic                    wen;
    } resp_tag_t;

    // Up/down counter step; simultaneous load and retire leaves the count unchanged.
    function automatic logic [2:0] cnt_next(logic [2:0] cnt, logic inc, logic dec);
        logic [2:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + 3'd1;
            2'b01:   nxt = cnt - 3'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tcdm_resp_delay_line.sv
// Fixed-depth shift register of response tags tracking requests through the bank latency.
// Shifts every cycle with no stall; clr empties every stage synchronously.
module tcdm_resp_delay_line
    import tcdm_interco_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk,
    input  logic      clr,
    input  resp_tag_t load_tag,
    output resp_tag_t last_tag
);

    resp_tag_t stage_q [Depth];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= load_tag;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign last_tag = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_resp_gen.sv
// Bank-side response generator: tracks accepted requests through the bank latency and emits a
// one-hot per-master valid with gated read data. Optional output register: TCDM_RESP_REG_EN.
module tcdm_bank_resp_gen
    import tcdm_interco_pkg::*;
#(
    parameter int unsigned N_MASTER   = 8,
    parameter int unsigned ID_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BANK_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_accept_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    input  logic                  req_wen_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [N_MASTER-1:0]   data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [2:0]            outstanding_o,
    output logic                  id_err_o
);

    logic                  id_ok;
    logic                  retire;
    resp_tag_t             load_tag;
    resp_tag_t             last_tag;
    logic [N_MASTER-1:0]   hit_valid;
    logic [DATA_WIDTH-1:0] hit_rdata;
    logic [2:0]            cnt_q;
    logic                  err_q;

    assign id_ok = 32'(req_id_i) < N_MASTER;

    // Out-of-range requests never enter the delay line.
    always_comb begin
        load_tag       = '0;
        load_tag.valid = req_accept_i & id_ok;
        load_tag.id    = MAX_ID_WIDTH'(req_id_i);
        load_tag.wen   = req_wen_i;
    end

    tcdm_resp_delay_line #(
        .Depth (BANK_LAT)
    ) u_delay_line (
        .clk      (clk),
        .clr      (rst),
        .load_tag (load_tag),
        .last_tag (last_tag)
    );

    always_comb begin
        hit_valid = '0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            hit_valid[i] = last_tag.valid && (last_tag.id == MAX_ID_WIDTH'(i));
        end
        hit_rdata = (last_tag.valid && !last_tag.wen) ? mem_rdata_i : '0;
    end

`ifdef TCDM_RESP_REG_EN
    logic [N_MASTER-1:0]   resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= hit_valid;
            resp_rdata_q <= hit_rdata;
        end
    end

    assign data_r_valid_o = resp_valid_q;
    assign data_r_rdata_o = resp_rdata_q;
    // An entry moving from the delay line into the output register stays outstanding.
    assign retire         = |resp_valid_q;
`else
    assign data_r_valid_o = hit_valid;
    assign data_r_rdata_o = hit_rdata;
    assign retire         = last_tag.valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next(cnt_q, load_tag.valid, retire);
            if (req_accept_i && !id_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = cnt_q;
    assign id_err_o      = err_q;

endmodule

// File: tb/tb_tcdm_bank_resp_gen.sv
// Scoreboard bench for tcdm_bank_resp_gen: stimulus queues expected responses, a negedge monitor
// compares valid, data, outstanding count and error flag every cycle.
module tb_tcdm_bank_resp_gen;

    localparam int unsigned NM  = 6;
    localparam int unsigned IDW = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned BL  = 3;
`ifdef TCDM_RESP_REG_EN
    localparam int unsigned LAT_OUT = BL + 1;
`else
    localparam int unsigned LAT_OUT = BL;
`endif
    localparam int NEVER = 32'h3fff_ffff;

    typedef struct {
        int            issue;
        int            resp;
        logic [NM-1:0] valid;
        logic [DW-1:0] data;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           acc;
    logic [IDW-1:0] rid;
    logic           wen;
    logic [DW-1:0]  mem_rdata;
    logic [NM-1:0]  r_valid;
    logic [DW-1:0]  r_rdata;
    logic [2:0]     outstanding;
    logic           id_err;

    exp_t          q[$];
    logic [DW-1:0] sched[int];
    int            cyc;
    int            err_set_cyc;
    int            n_pass;
    int            n_total;
    logic          mon_en;

    logic [NM-1:0] exp_v;
    logic [DW-1:0] exp_d;
    int            exp_out;

    tcdm_bank_resp_gen #(
        .N_MASTER   (NM),
        .ID_WIDTH   (IDW),
        .DATA_WIDTH (DW),
        .BANK_LAT   (BL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_accept_i   (acc),
        .req_id_i       (rid),
        .req_wen_i      (wen),
        .mem_rdata_i    (mem_rdata),
        .data_r_valid_o (r_valid),
        .data_r_rdata_o (r_rdata),
        .outstanding_o  (outstanding),
        .id_err_o       (id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: scheduled read data in its cycle, otherwise all-ones junk.
    always begin
        @(posedge clk);
        #1;
        mem_rdata = sched.exists(cyc) ? sched[cyc] : 32'hFFFF_FFFF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // Drive one cycle of request inputs; push records the expected outcome.
    task automatic step(input logic a, input int id, input logic w, input logic [DW-1:0] d,
                        input logic push);
        exp_t e;
        acc = a;
        rid = IDW'(id);
        wen = w;
        if (a && push) begin
            if (id < int'(NM)) begin
                e.issue = cyc;
                e.resp  = cyc + int'(LAT_OUT);
                e.valid = NM'(1) << id;
                e.data  = w ? '0 : d;
                q.push_back(e);
                sched[cyc + int'(BL)] = d;
            end else if (err_set_cyc == NEVER) begin
                err_set_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_v   = '0;
            exp_d   = '0;
            exp_out = 0;
            foreach (q[i]) if (q[i].issue < cyc) exp_out++;
            if (q.size() > 0 && q[0].resp == cyc) begin
                exp_v = q[0].valid;
                exp_d = q[0].data;
                void'(q.pop_front());
            end
            chk("valid", 64'(r_valid), 64'(exp_v));
            chk("rdata", 64'(r_rdata), 64'(exp_d));
            chk("outstanding", 64'(outstanding), 64'(exp_out));
            chk("id_err", 64'(id_err), 64'(cyc > err_set_cyc));
        end
    end

    initial begin
        n_pass      = 0;
        n_total     = 0;
        err_set_cyc = NEVER;
        mon_en      = 1'b0;
        rst         = 1'b1;
        acc         = 1'b0;
        rid         = '0;
        wen         = 1'b0;
        mem_rdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Single read
        step(1'b1, 5, 1'b0, 32'hDEAD_BEEF, 1'b1);
        idle(LAT_OUT + 2);

        // Back-to-back reads, outstanding peaks at BL (BL+1 with output register)
        for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 32'h1111_1111 * (i + 1), 1'b1);
        idle(LAT_OUT + 2);

        // Write: data gated to zero although the bank drives all ones
        step(1'b1, 2, 1'b1, 32'hFFFF_FFFF, 1'b1);
        idle(LAT_OUT + 2);

        // Out-of-range ids: dropped, sticky error
        step(1'b1, 7, 1'b0, 32'h0BAD_0007, 1'b1);
        step(1'b1, 6, 1'b0, 32'h0BAD_0006, 1'b1);
        idle(LAT_OUT + 2);

        // Mixed reads/writes every cycle
        step(1'b1, 4, 1'b0, 32'hA4A4_0004, 1'b1);
        step(1'b1, 3, 1'b1, 32'hB3B3_0003, 1'b1);
        step(1'b1, 0, 1'b0, 32'hC0C0_0000, 1'b1);
        step(1'b1, 5, 1'b0, 32'hD5D5_0005, 1'b1);
        idle(LAT_OUT + 2);

        // Reset while a read is in flight; requests during reset are ignored
        step(1'b1, 1, 1'b0, 32'h5555_AAAA, 1'b1);
        rst = 1'b1;
        step(1'b1, 7, 1'b0, 32'h0, 1'b0);
        q.delete();
        err_set_cyc = NEVER;
        step(1'b1, 1, 1'b0, 32'h7777_7777, 1'b0);
        rst = 1'b0;
        idle(LAT_OUT + 3);

        // Recovery after reset
        step(1'b1, 3, 1'b0, 32'h0000_1234, 1'b1);
        idle(LAT_OUT + 3);

        mon_en = 1'b0;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d queued responses, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
